// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - program-load, instruction-memory write and run handshake bundle
interface cpu_run_ctrl_if #(
  parameter int IW    = 9,
  parameter int AW    = 10,
  parameter int CNT_W = 24
);
  logic             load_req;
  logic             ld_valid;
  logic             ld_ready;
  logic [IW-1:0]    ld_data;
  logic             ld_last;
  logic             im_we;
  logic [AW-1:0]    im_addr;
  logic [IW-1:0]    im_wdata;
  logic             run_req;
  logic             start;
  logic             done;
  logic             busy;
  logic             run_done;
  logic             timed_out;
  logic [CNT_W-1:0] cycle_count;
  logic [AW:0]      load_count;

  modport master (
    output load_req, ld_valid, ld_data, ld_last, run_req, done,
    input  ld_ready, im_we, im_addr, im_wdata, start, busy, run_done,
           timed_out, cycle_count, load_count
  );

  modport slave (
    input  load_req, ld_valid, ld_data, ld_last, run_req, done,
    output ld_ready, im_we, im_addr, im_wdata, start, busy, run_done,
           timed_out, cycle_count, load_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - program loader and start/done run sequencer; RUN_WATCHDOG_EN enables the run timeout
module cpu_run_ctrl #(
  parameter int IW             = 9,
  parameter int AW             = 10,
  parameter int START_CYCLES   = 2,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic          clk,
  input logic          rst_n,
  cpu_run_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;
  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  logic [1:0]       state;
  logic [AW-1:0]    addr;
  logic [AW:0]      lcount;
  logic [SC_W-1:0]  st_cnt;
  logic [CNT_W-1:0] ccount;
  logic [CNT_W-1:0] ccount_inc;
  logic             rdone;
  logic             tout;
  logic             accept;
  logic             last_word;
  logic             cnt_hit;

  assign accept    = (state == S_LOAD) && bus.ld_valid;
  // Writing the top address ends the load even without ld_last, so the address never wraps.
  assign last_word = bus.ld_last || (addr == {AW{1'b1}});

`ifdef RUN_WATCHDOG_EN
  assign ccount_inc = ccount + CNT_W'(1);
  assign cnt_hit    = (ccount_inc == CNT_W'(TIMEOUT_CYCLES));
`else
  assign ccount_inc = (&ccount) ? ccount : ccount + CNT_W'(1);
  assign cnt_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr   <= '0;
      lcount <= '0;
      st_cnt <= '0;
      ccount <= '0;
      rdone  <= 1'b0;
      tout   <= 1'b0;
    end else begin
      rdone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load_req) begin
            state  <= S_LOAD;
            addr   <= '0;
            lcount <= '0;
          end else if (bus.run_req) begin
            state  <= S_START;
            st_cnt <= '0;
            ccount <= '0;
            tout   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            lcount <= lcount + (AW+1)'(1);
            if (!(&addr)) addr <= addr + AW'(1);
            if (last_word) state <= S_IDLE;
          end
        end
        S_START: begin
          if (st_cnt == SC_W'(START_CYCLES - 1)) state <= S_RUN;
          else st_cnt <= st_cnt + SC_W'(1);
        end
        S_RUN: begin
          ccount <= ccount_inc;
          // done takes priority over a timeout landing in the same cycle
          if (bus.done) begin
            state <= S_IDLE;
            rdone <= 1'b1;
          end else if (cnt_hit) begin
            state <= S_IDLE;
            rdone <= 1'b1;
            tout  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ld_ready    = (state == S_LOAD);
  assign bus.im_we       = accept;
  assign bus.im_addr     = addr;
  assign bus.im_wdata    = bus.ld_data;
  assign bus.start       = (state != S_RUN);
  assign bus.busy        = (state != S_IDLE);
  assign bus.run_done    = rdone;
  assign bus.timed_out   = tout;
  assign bus.cycle_count = ccount;
  assign bus.load_count  = lcount;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;
  localparam int IW = 9;
  localparam int AW = 10;
  localparam int SC = 2;
  localparam int CW = 5;
  localparam int TO = 16;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;
  int   wr_addr[$];
  int   wr_data[$];
  logic prev_rd = 1'b0;

  typedef struct {
    int done_at;
    int exp_cnt;
    bit exp_to;
    int exp_end;
  } run_vec_t;
  run_vec_t tbl[5];

  cpu_run_ctrl_if #(.IW(IW), .AW(AW), .CNT_W(CW)) bus ();

  cpu_run_ctrl #(
    .IW(IW), .AW(AW), .START_CYCLES(SC), .CNT_W(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.im_we === 1'b1) begin
        wr_addr.push_back(int'(bus.im_addr));
        wr_data.push_back(int'(bus.im_wdata));
      end
      if (bus.run_done === 1'b1) chk("run_done_single", prev_rd, 1'b0);
      prev_rd = bus.run_done;
    end
  end

  function automatic void run_model(input int done_at, output int end_cyc, output int cnt,
                                    output bit to);
`ifdef RUN_WATCHDOG_EN
    to      = (done_at > TO);
    end_cyc = to ? TO : done_at;
    cnt     = end_cyc;
`else
    to      = 1'b0;
    end_cyc = done_at;
    cnt     = (done_at > SAT) ? SAT : done_at;
`endif
  endfunction

  task automatic do_run(input string tag, input int done_at, input int exp_cnt,
                        input bit exp_to, input int exp_end);
    int r;
    bit ended;
    bus.run_req = 1'b1;
    @(posedge clk); #1 bus.run_req = 1'b0;
    for (int i = 0; i < SC; i++) begin
      @(negedge clk); chk({tag, "_start_held"}, bus.start, 1'b1);
      @(posedge clk); #1;
    end
    r = 0;
    ended = 1'b0;
    while (!ended && r < 100) begin
      r++;
      bus.done = (r == done_at);
      if (r == 1) begin
        @(negedge clk); chk({tag, "_start_low"}, bus.start, 1'b0);
      end
      @(posedge clk); #1;
      if (!bus.busy) ended = 1'b1;
    end
    bus.done = 1'b0;
    chk({tag, "_run_cycles"}, r, exp_end);
    chk({tag, "_run_done"}, bus.run_done, 1'b1);
    chk({tag, "_cycle_count"}, bus.cycle_count, exp_cnt);
    chk({tag, "_timed_out"}, bus.timed_out, exp_to);
    @(posedge clk); #1;
    chk({tag, "_run_done_fall"}, bus.run_done, 1'b0);
  endtask

  task automatic do_load(input string tag, input int n, input bit use_last, input int gap,
                         input bit pattern, input bit mix);
    int words[$];
    int w;
    int g;
    int bad;
    wr_addr.delete();
    wr_data.delete();
    bus.load_req = 1'b1;
    bus.run_req  = mix;
    @(posedge clk); #1 bus.load_req = 1'b0;
    chk({tag, "_ld_ready"}, bus.ld_ready, 1'b1);
    chk({tag, "_start_in_load"}, bus.start, 1'b1);
    for (int i = 0; i < n; i++) begin
      g = 0;
      while (g < 5 && $urandom_range(99) < gap) begin
        bus.ld_valid = 1'b0;
        g++;
        @(posedge clk); #1;
      end
      w = pattern ? i + 1 : int'($urandom_range((1 << IW) - 1));
      words.push_back(w);
      bus.ld_valid = 1'b1;
      bus.ld_data  = IW'(w);
      bus.ld_last  = use_last && (i == n - 1);
      @(posedge clk); #1;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.run_req  = 1'b0;
    chk({tag, "_busy_fall"}, bus.busy, 1'b0);
    chk({tag, "_load_count"}, bus.load_count, n);
    chk({tag, "_nwrites"}, wr_addr.size(), n);
    bad = 0;
    for (int i = 0; i < n && i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_data[i] != words[i]) bad++;
    chk({tag, "_write_content"}, bad, 0);
    bus.ld_valid = 1'b1;
    @(posedge clk); #1 bus.ld_valid = 1'b0;
    chk({tag, "_no_write_idle"}, wr_addr.size(), n);
    chk({tag, "_idle_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    int de, dc;
    bit dt;
    int n;
`ifdef RUN_WATCHDOG_EN
    tbl[0] = '{1, 1, 1'b0, 1};
    tbl[1] = '{7, 7, 1'b0, 7};
    tbl[2] = '{16, 16, 1'b0, 16};
    tbl[3] = '{17, 16, 1'b1, 16};
    tbl[4] = '{40, 16, 1'b1, 16};
`else
    tbl[0] = '{1, 1, 1'b0, 1};
    tbl[1] = '{7, 7, 1'b0, 7};
    tbl[2] = '{16, 16, 1'b0, 16};
    tbl[3] = '{17, 17, 1'b0, 17};
    tbl[4] = '{40, SAT, 1'b0, 40};
`endif
    bus.load_req = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.run_req  = 1'b0;
    bus.done     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", bus.start, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ld_ready", bus.ld_ready, 1'b0);
    chk("rst_run_done", bus.run_done, 1'b0);
    chk("rst_load_count", bus.load_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) do_run($sformatf("tbl%0d", i), tbl[i].done_at,
                                       tbl[i].exp_cnt, tbl[i].exp_to, tbl[i].exp_end);

    do_load("ld5", 5, 1'b1, 50, 1'b1, 1'b0);
    do_load("ld1024", 1024, 1'b0, 0, 1'b0, 1'b0);
    do_load("mixreq", 3, 1'b1, 20, 1'b1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      n = int'($urandom_range(1, 40));
      run_model(n, de, dc, dt);
      do_run($sformatf("rnd_run%0d", i), n, dc, dt, de);
    end
    for (int i = 0; i < 4; i++)
      do_load($sformatf("rnd_ld%0d", i), int'($urandom_range(1, 30)), 1'b1, 40, 1'b0, 1'b0);

    bus.run_req = 1'b1;
    @(posedge clk); #1 bus.run_req = 1'b0;
    repeat (SC + 4) @(posedge clk);
    #1;
    chk("midrun_count", bus.cycle_count, 4);
    bus.ld_data = 9'h155;
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_start", bus.start, 1'b1);
    chk("midrun_rst_busy", bus.busy, 1'b0);
    chk("midrun_rst_count", bus.cycle_count, 0);
    chk("midrun_rst_timed_out", bus.timed_out, 1'b0);
    chk("midrun_rst_im_we", bus.im_we, 1'b0);
    chk("midrun_rst_im_addr", bus.im_addr, 0);
    chk("midrun_rst_wdata_pass", bus.im_wdata, 9'h155);
    @(posedge clk); #1 rst_n = 1'b1;
    do_run("after_rst", 7, 7, 1'b0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Host-side sequencer that owns the processor's `start`/`done` handshake. It streams a program into instruction memory through a write port, then launches a run by holding `start` for a minimum number of cycles. It waits for `done`, counts executed cycles and reports completion or timeout. It sits between the test host and the processor top level, on the opposite end of `start`/`done`, and drives the instruction-memory write side.

## Interface
Parameters:
- `IW`, default 9, instruction word width.
- `AW`, default 10, instruction address width (matches PC).
- `START_CYCLES`, default 2, cycles `start` is held in START (legal ≥1).
- `CNT_W`, default 24, cycle counter width.
- `TIMEOUT_CYCLES`, default 4096, watchdog limit (must be < 2^CNT_W).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_req`  in  1  request program load (sampled in IDLE).
- `ld_valid`  in  1  program word valid.
- `ld_ready`  out  1  word accepted this cycle when `ld_valid` is also high.
- `ld_data`  in  IW  program word.
- `ld_last`  in  1  final word of program.
- `im_we`  out  1  instruction memory write enable.
- `im_addr`  out  AW  instruction memory write address.
- `im_wdata`  out  IW  instruction memory write data.
- `run_req`  in  1  request a run (sampled in IDLE).
- `start`  out  1  to processor; high parks PC at 0.
- `done`  in  1  from processor; halt indication.
- `busy`  out  1  high in any state other than IDLE.
- `run_done`  out  1  one-cycle pulse, run finished.
- `timed_out`  out  1  last run ended by watchdog; held until the next run starts.
- `cycle_count`  out  CNT_W  RUN cycles of the last run, including the `done` cycle.
- `load_count`  out  AW+1  words written by the last load.

## Operation
- States are IDLE, LOAD, START and RUN. Outputs are Moore-decoded from registered state, except the `im_*` signals.
- IDLE:
  - `start`=1 (processor parked).
  - If `load_req`=1, go to LOAD. Clear the address counter and `load_count`.
  - Else if `run_req`=1, go to START. Clear `cycle_count` and `timed_out`.
  - If both are high, `load_req` wins. Both are ignored outside IDLE.
- LOAD:
  - `ld_ready`=1 and `start`=1.
  - `im_we` = `ld_valid`. `im_addr` = address counter. `im_wdata` = `ld_data`, combinational.
  - Each accepted word increments the address and `load_count`.
  - Exit to IDLE after accepting a word with `ld_last`=1, or after writing address 2^AW−1. On the auto-terminate case `load_count` = 2^AW.
  - The address never wraps.
- START: `start`=1 for exactly START_CYCLES cycles, then go to RUN. `done` is ignored in START.
- RUN:
  - `start`=0. Each cycle, `cycle_count` increments by 1.
  - If `done`=1, go to IDLE. `run_done` pulses the next cycle with `timed_out`=0.
  - Else, if the incremented count equals TIMEOUT_CYCLES, go to IDLE. `timed_out`=1 and `run_done` pulses.
  - If `done` and timeout occur in the same cycle, `done` wins.
- Reset (async, any state, including mid-load or mid-run):
  - Next state is IDLE.
  - `start`=1.
  - `ld_ready`, `im_we`, `busy`, `run_done` and `timed_out` are 0.
  - `im_addr`, `cycle_count` and `load_count` are 0.
  - `im_wdata` = `ld_data`, which is passthrough, not reset.
- `cycle_count` and `load_count` hold their values in IDLE until the next run or load clears them.

## Timing
- `run_req` sampled at edge k → START covers edges k+1 … k+START_CYCLES. `start` falls after edge k+START_CYCLES.
- `done` high in the first RUN cycle → `cycle_count`=1. `run_done` is high for one cycle, and `busy` falls in that same cycle.
- Write latency is 0: each word is written in the cycle it is accepted, with the `im_*` signals combinational from `ld_valid`/`ld_data`.
- `run_done` is never high for two consecutive cycles.
- A new request is accepted no earlier than the cycle in which `run_done` is high.

## Configuration
- `RUN_WATCHDOG_EN` defined: the watchdog is active as described above.
- `RUN_WATCHDOG_EN` undefined:
  - No timeout; RUN exits only on `done`.
  - `timed_out` is tied to 0.
  - `cycle_count` saturates at 2^CNT_W−1 instead of wrapping.

## Test plan
- Reset: `rst_n` low mid-RUN → immediately `start`=1, `busy`=0, `cycle_count`=0, state IDLE.
- Load 5 words 0x001…0x005, `ld_last` on the 5th, with `ld_valid` gaps → writes at addresses 0–4 only, `load_count`=5, `busy` falls after the 5th word.
- Load 1024 words with no `ld_last` → last write at address 1023, `load_count`=1024, exit to IDLE, no wrap to address 0.
- Run with `done` asserted on the 7th RUN cycle → `start` high for exactly 2 cycles after the request, `cycle_count`=7, one `run_done` pulse, `timed_out`=0.
- With watchdog enabled, TIMEOUT_CYCLES=16, `done` held low → `cycle_count`=16, `timed_out`=1, `run_done` pulse. Repeat with `done` raised exactly on the 16th cycle → `timed_out`=0.
- `load_req` and `run_req` high together in IDLE → LOAD entered. `run_req` asserted during LOAD is ignored.
